// File: rtl/ss_ptr_tracker.sv
// rtl/ss_ptr_tracker.sv - shadow-stack pointer tracker with speculative/committed SSP and push queue
module ss_ptr_tracker #(
    parameter int SSP_W      = 64,
    parameter int SLOT_BYTES = 8,
    parameter int DEPTH      = 4,
    parameter int TID_W      = 3
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             csr_ssp_we_i,
    input  logic [SSP_W-1:0] csr_ssp_i,
    input  logic [SSP_W-1:0] ss_base_i,
    input  logic             wb_valid_i,
    input  logic [TID_W-1:0] wb_trans_id_i,
    input  logic             wb_ss_push_i,
    input  logic             wb_ex_valid_i,
    input  logic             commit_i,
    input  logic [TID_W-1:0] commit_trans_id_i,
    output logic             ready_o,
    output logic [SSP_W-1:0] ssp_o,
    output logic [SSP_W-1:0] committed_ssp_o,
    output logic             overflow_o,
    output logic [TID_W-1:0] overflow_trans_id_o,
    output logic             pending_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [SSP_W-1:0] SLOT      = SSP_W'(SLOT_BYTES);
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

    logic [SSP_W-1:0] ssp_q;
    logic [SSP_W-1:0] committed_q;
    logic [TID_W-1:0] tag_q [DEPTH];
    logic [PTR_W-1:0] head_q;
    logic [PTR_W-1:0] tail_q;
    logic [CNT_W-1:0] count_q;
    logic             overflow_q;
    logic [TID_W-1:0] overflow_id_q;

    logic             push_cand;
    logic             limit_fail;
    logic             push_acc;
    logic             commit_hit;
    logic [SSP_W-1:0] committed_next;
    logic [CNT_W-1:0] count_next;

    // Classify this cycle's writeback and commit; a flush or CSR write masks pushes.
    always_comb begin
        push_cand      = wb_valid_i & wb_ss_push_i & ~wb_ex_valid_i & ~flush_i & ~csr_ssp_we_i;
        // One extra bit keeps base + slot from wrapping near the top of the address space.
        limit_fail     = {1'b0, ssp_q} < ({1'b0, ss_base_i} + {1'b0, SLOT});
        push_acc       = push_cand & ~limit_fail & (count_q < DEPTH_CNT);
        commit_hit     = commit_i & ~csr_ssp_we_i & (count_q != '0)
                         & (commit_trans_id_i == tag_q[head_q]);
        committed_next = commit_hit ? committed_q - SLOT : committed_q;
        count_next     = count_q;
        if (push_acc && !commit_hit) begin
            count_next = count_q + 1'b1;
        end else if (commit_hit && !push_acc) begin
            count_next = count_q - 1'b1;
        end
    end

    // SSP registers and the in-order queue of uncommitted push tags.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ssp_q       <= '0;
            committed_q <= '0;
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                tag_q[i] <= '0;
            end
        end else if (csr_ssp_we_i) begin
            ssp_q       <= csr_ssp_i;
            committed_q <= csr_ssp_i;
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
        end else if (flush_i) begin
            // Roll back to the architectural value, including a same-cycle commit.
            ssp_q       <= committed_next;
            committed_q <= committed_next;
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
        end else begin
            committed_q <= committed_next;
            count_q     <= count_next;
            if (commit_hit) begin
                head_q <= head_q + 1'b1;
            end
            if (push_acc) begin
                ssp_q         <= ssp_q - SLOT;
                tag_q[tail_q] <= wb_trans_id_i;
                tail_q        <= tail_q + 1'b1;
            end
        end
    end

    // Overflow pulse for one cycle; the id of the last rejected push is held.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            overflow_q    <= 1'b0;
            overflow_id_q <= '0;
        end else begin
            overflow_q <= push_cand & limit_fail;
            if (push_cand && limit_fail) begin
                overflow_id_q <= wb_trans_id_i;
            end
        end
    end

    assign ready_o             = count_q < DEPTH_CNT;
    assign pending_o           = count_q != '0;
    assign ssp_o               = ssp_q;
    assign committed_ssp_o     = committed_q;
    assign overflow_o          = overflow_q;
    assign overflow_trans_id_o = overflow_id_q;

endmodule

// File: tb/tb_ss_ptr_tracker.sv
// tb/tb_ss_ptr_tracker.sv - self-checking bench for ss_ptr_tracker against a queue-based model
module tb_ss_ptr_tracker;

    localparam int SSP_W = 64;
    localparam int SLOT  = 8;
    localparam int DEPTH = 4;
    localparam int TID_W = 3;

    logic             clk_i = 1'b0;
    logic             rst_ni;
    logic             flush_i;
    logic             csr_ssp_we_i;
    logic [SSP_W-1:0] csr_ssp_i;
    logic [SSP_W-1:0] ss_base_i;
    logic             wb_valid_i;
    logic [TID_W-1:0] wb_trans_id_i;
    logic             wb_ss_push_i;
    logic             wb_ex_valid_i;
    logic             commit_i;
    logic [TID_W-1:0] commit_trans_id_i;
    logic             ready_o;
    logic [SSP_W-1:0] ssp_o;
    logic [SSP_W-1:0] committed_ssp_o;
    logic             overflow_o;
    logic [TID_W-1:0] overflow_trans_id_o;
    logic             pending_o;

    int n_checks = 0;
    int n_pass   = 0;

    logic [SSP_W-1:0] m_ssp;
    logic [SSP_W-1:0] m_com;
    logic [TID_W-1:0] mq [$];
    logic             m_ovf;
    logic [TID_W-1:0] m_ovf_id;

    ss_ptr_tracker #(.SSP_W(SSP_W), .SLOT_BYTES(SLOT), .DEPTH(DEPTH), .TID_W(TID_W)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
        .csr_ssp_we_i(csr_ssp_we_i), .csr_ssp_i(csr_ssp_i), .ss_base_i(ss_base_i),
        .wb_valid_i(wb_valid_i), .wb_trans_id_i(wb_trans_id_i), .wb_ss_push_i(wb_ss_push_i),
        .wb_ex_valid_i(wb_ex_valid_i), .commit_i(commit_i), .commit_trans_id_i(commit_trans_id_i),
        .ready_o(ready_o), .ssp_o(ssp_o), .committed_ssp_o(committed_ssp_o),
        .overflow_o(overflow_o), .overflow_trans_id_o(overflow_trans_id_o), .pending_o(pending_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [SSP_W-1:0] obs, input logic [SSP_W-1:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".ssp"}, ssp_o, m_ssp);
        chk({tag, ".com"}, committed_ssp_o, m_com);
        chk({tag, ".ready"}, SSP_W'(ready_o), SSP_W'(mq.size() < DEPTH));
        chk({tag, ".pending"}, SSP_W'(pending_o), SSP_W'(mq.size() != 0));
        chk({tag, ".ovf"}, SSP_W'(overflow_o), SSP_W'(m_ovf));
        chk({tag, ".ovf_id"}, SSP_W'(overflow_trans_id_o), SSP_W'(m_ovf_id));
    endtask

    task automatic model_reset();
        m_ssp = '0; m_com = '0; mq.delete(); m_ovf = 1'b0; m_ovf_id = '0;
    endtask

    // Apply one cycle of inputs, advance the reference model, then compare after the edge.
    task automatic step(input string tag, input bit v, input int tid, input bit p, input bit ex,
                        input bit c, input int cid, input bit fl, input bit we,
                        input logic [SSP_W-1:0] wval);
        bit cand, fail, full, hit;
        wb_valid_i = v; wb_trans_id_i = TID_W'(tid); wb_ss_push_i = p; wb_ex_valid_i = ex;
        commit_i = c; commit_trans_id_i = TID_W'(cid); flush_i = fl;
        csr_ssp_we_i = we; csr_ssp_i = wval;
        cand = v && p && !ex && !fl && !we;
        fail = {1'b0, m_ssp} < ({1'b0, ss_base_i} + (SSP_W+1)'(SLOT));
        full = mq.size() == DEPTH;
        hit  = c && !we && mq.size() != 0 && mq[0] == TID_W'(cid);
        m_ovf = cand && fail;
        if (m_ovf) m_ovf_id = TID_W'(tid);
        if (we) begin
            m_ssp = wval; m_com = wval; mq.delete();
        end else begin
            if (hit) begin
                m_com = m_com - SLOT;
                void'(mq.pop_front());
            end
            if (fl) begin
                mq.delete(); m_ssp = m_com;
            end else if (cand && !fail && !full) begin
                m_ssp = m_ssp - SLOT;
                mq.push_back(TID_W'(tid));
            end
        end
        @(posedge clk_i);
        #1;
        chk_all(tag);
    endtask

    task automatic idle(input string tag);
        step(tag, 0, 0, 0, 0, 0, 0, 0, 0, '0);
    endtask

    task automatic push(input string tag, input int tid);
        step(tag, 1, tid, 1, 0, 0, 0, 0, 0, '0);
    endtask

    task automatic commit(input string tag, input int cid);
        step(tag, 0, 0, 0, 0, 1, cid, 0, 0, '0);
    endtask

    task automatic csr(input string tag, input logic [SSP_W-1:0] val);
        step(tag, 0, 0, 0, 0, 0, 0, 0, 1, val);
    endtask

    initial begin
        rst_ni = 1'b0; flush_i = 0; csr_ssp_we_i = 0; csr_ssp_i = '0; ss_base_i = '0;
        wb_valid_i = 0; wb_trans_id_i = '0; wb_ss_push_i = 0; wb_ex_valid_i = 0;
        commit_i = 0; commit_trans_id_i = '0;
        model_reset();
        repeat (3) @(posedge clk_i);
        #1;
        chk_all("reset");
        rst_ni = 1'b1;

        // Basic push and commit
        ss_base_i = 64'h0F00;
        csr("t1.csr", 64'h1000);
        push("t1.p2", 2);
        chk("t1.ssp_ff8", ssp_o, 64'hFF8);
        push("t1.p3", 3);
        chk("t1.ssp_ff0", ssp_o, 64'hFF0);
        commit("t1.c2", 2);
        chk("t1.com_ff8", committed_ssp_o, 64'hFF8);
        chk("t1.pend1", SSP_W'(pending_o), 64'd1);
        commit("t1.c3", 3);
        chk("t1.com_ff0", committed_ssp_o, 64'hFF0);
        chk("t1.pend0", SSP_W'(pending_o), 64'd0);

        // Limit check
        ss_base_i = 64'h0FF0;
        csr("t2.csr", 64'h0FF8);
        push("t2.p5", 5);
        chk("t2.ssp_ff0", ssp_o, 64'hFF0);
        push("t2.p6", 6);
        chk("t2.ovf", SSP_W'(overflow_o), 64'd1);
        chk("t2.ovf_id", SSP_W'(overflow_trans_id_o), 64'd6);
        chk("t2.ssp_hold", ssp_o, 64'hFF0);
        idle("t2.idle");
        chk("t2.ovf_pulse", SSP_W'(overflow_o), 64'd0);

        // Exception and non-matching commit
        ss_base_i = '0;
        csr("t3.csr", 64'h1000);
        push("t3.p1", 1);
        step("t3.ex", 1, 4, 1, 1, 0, 0, 0, 0, '0);
        chk("t3.ex_ssp", ssp_o, 64'hFF8);
        commit("t3.c7", 7);
        chk("t3.c7_com", committed_ssp_o, 64'h1000);

        // Full queue
        csr("t4.csr", 64'h1000);
        for (int i = 0; i < 4; i++) push("t4.fill", i);
        chk("t4.ready0", SSP_W'(ready_o), 64'd0);
        push("t4.drop", 4);
        chk("t4.drop_ssp", ssp_o, 64'hFE0);
        step("t4.cp", 1, 5, 1, 0, 1, 0, 0, 0, '0);
        chk("t4.cp_ready", SSP_W'(ready_o), 64'd1);
        chk("t4.cp_ssp", ssp_o, 64'hFE0);

        // Flush with same-cycle commit
        csr("t5.csr", 64'h1000);
        push("t5.p1", 1); push("t5.p2", 2); push("t5.p3", 3);
        chk("t5.ssp_fe8", ssp_o, 64'hFE8);
        commit("t5.c1", 1);
        step("t5.flush", 0, 0, 0, 0, 1, 2, 1, 0, '0);
        chk("t5.ssp", ssp_o, 64'hFF0);
        chk("t5.com", committed_ssp_o, 64'hFF0);
        chk("t5.pend", SSP_W'(pending_o), 64'd0);

        // CSR priority
        csr("t6.csr", 64'h1000);
        push("t6.p1", 1);
        step("t6.prio", 1, 2, 1, 0, 1, 1, 0, 1, 64'h2000);
        chk("t6.ssp", ssp_o, 64'h2000);
        chk("t6.com", committed_ssp_o, 64'h2000);
        chk("t6.pend", SSP_W'(pending_o), 64'd0);

        // Randomized traffic honouring ready
        for (int n = 0; n < 400; n++) begin
            int r, tid, cid;
            bit v, p, ex, c, fl, we;
            r = int'($urandom_range(0, 99));
            if (n % 50 == 0) ss_base_i = 64'(($urandom_range(0, 8)) * SLOT);
            we  = r < 4;
            fl  = r >= 4 && r < 8;
            v   = $urandom_range(0, 1) == 1;
            p   = $urandom_range(0, 3) != 0;
            ex  = $urandom_range(0, 7) == 0;
            tid = int'($urandom_range(0, 7));
            c   = $urandom_range(0, 1) == 1;
            cid = (mq.size() != 0 && $urandom_range(0, 3) != 0) ? int'(mq[0])
                                                                : int'($urandom_range(0, 7));
            if (mq.size() == DEPTH) v = 0;
            step("rnd", v, tid, p, ex, c, cid, fl, we,
                 64'(($urandom_range(0, 24)) * SLOT));
        end

        // Asynchronous reset mid-queue
        csr("t7.csr", 64'h1000);
        push("t7.p1", 1);
        push("t7.p2", 2);
        #3;
        rst_ni = 1'b0;
        #1;
        model_reset();
        chk_all("t7.async");
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        idle("t7.after");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
